mem_copy: RTL

MEM_COPY -- requirements
Module: mem_copy

---
 rtl/mem_copy_pkg.sv | 19 +
 rtl/mem_copy.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the mem_copy word-copy engine.
// The MEM_COPY_CHECKSUM_EN option itself lives in mem_copy.sv.
package mem_copy_pkg;

    localparam int unsigned WORD_BYTES = 2;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 16;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mem_copy.sv
// Word-by-word memory copy engine, 3 cycles per word (read, wait, write).
// Define MEM_COPY_CHECKSUM_EN to add the running-sum checksum output.
module mem_copy
    import mem_copy_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_src_nxt;
    logic [ADDR_W-1:0] w_dst_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
    logic [DATA_W-1:0] w_csum_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_cnt_nxt   = r_cnt;
        w_wdata_nxt = r_wdata;
`ifdef MEM_COPY_CHECKSUM_EN
        w_csum_nxt  = r_csum;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef MEM_COPY_CHECKSUM_EN
                    w_csum_nxt = '0;
`endif
                    if (len != '0) begin
                        w_src_nxt   = src_addr;
                        w_dst_nxt   = dst_addr;
                        w_cnt_nxt   = len;
                        w_state_nxt = RD;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            RD: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_wdata_nxt = rd_data;
                w_state_nxt = WR;
            end
            WR: begin
                w_src_nxt   = r_src + ADDR_STEP;
                w_dst_nxt   = r_dst + ADDR_STEP;
                w_cnt_nxt   = r_cnt - 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
                w_csum_nxt  = r_csum + r_wdata;
`endif
                w_state_nxt = (r_cnt == 8'd1) ? DONE : RD;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        w_addr_nxt = r_addr;
        if (w_state_nxt == RD) begin
            w_addr_nxt = w_src_nxt;
        end else if (w_state_nxt == WR) begin
            w_addr_nxt = w_dst_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_src       <= w_src_nxt;
            r_dst       <= w_dst_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
            r_mem_read  <= (w_state_nxt == RD);
            r_mem_write <= (w_state_nxt == WR);
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum <= '0;
        end else begin
            r_csum <= w_csum_nxt;
        end
    end

    assign checksum = r_csum;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign MemRead  = r_mem_read;
    assign MemWrite = r_mem_write;
    assign addr_out = r_addr;
    assign wr_data  = r_wdata;

endmodule
